// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared state type and constants for down_timer
package down_timer_pkg;

  // Two-state control: IDLE waits for a load, RUN counts down on EN
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] ALL_ZEROS = {DEFAULT_WIDTH{1'b0}};
  localparam logic [DEFAULT_WIDTH-1:0] ALL_ONES  = {DEFAULT_WIDTH{1'b1}};

endpackage

// File: rtl/down_timer.sv
// rtl/down_timer.sv - cascadable loadable down counter with expiry pulse; option macro DOWN_TIMER_AUTO_RELOAD_EN
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             DONE,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] q_d;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rld_q;

  // Reload register remembers the last loaded value for periodic restarts
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rld_q <= Q_ZERO;
    end else if (LOAD) begin
      rld_q <= D;
    end
  end
`endif

  // Next-state, next-count and borrow-out; LOAD wins over counting, IDLE ignores EN
  always_comb begin
    state_d = state_q;
    q_d     = Q;
    BO      = 1'b0;
    if (LOAD) begin
      q_d     = D;
      state_d = RUN;
    end else if (state_q == RUN && EN) begin
      if (Q == Q_ZERO) begin
        BO = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        q_d = rld_q;
`else
        state_d = IDLE;
`endif
      end else begin
        q_d = Q - Q_ONE;
      end
    end
  end

  // State, count and expiry pulse registers; reset dominates everything
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      Q       <= Q_ZERO;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      Q       <= q_d;
      DONE    <= BO;
    end
  end

  assign BUSY = (state_q == RUN);

endmodule
